// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, gates bundle pushes to the
// decode queue and runs the icache miss/refill handshake.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int          LINE_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic        pc_check_enable,
  input  logic [31:0] pc_check_new,
  input  logic [2:0]  valid_number,
  input  logic        icache_hit,
  input  logic        dq_ready,
  output logic        bundle_valid,
  output logic [2:0]  bundle_count,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        refill_req,
  output logic [31:0] refill_addr,
  input  logic        refill_ack,
  output logic [15:0] miss_count
);

  localparam int OFF = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    MISS,
    MISS_FLUSH
  } state_t;

  state_t      state;
  logic [31:0] pending_pc;
  logic [31:0] rpc_a;
  logic [31:0] pcn_a;
  logic [31:0] seq_pc;
  logic [31:0] line_addr;

  assign rpc_a     = {redirect_pc[31:2], 2'b00};
  assign pcn_a     = {pc_check_new[31:2], 2'b00};
  assign seq_pc    = pc + {27'd0, valid_number, 2'b00};
  assign line_addr = {pc[31:OFF], {OFF{1'b0}}};

  assign bundle_valid = (state == RUN) & icache_hit
                      & ~redirect_valid;
  assign bundle_count = bundle_valid ? valid_number : 3'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pending_pc  <= 32'd0;
      refill_req  <= 1'b0;
      refill_addr <= 32'd0;
      miss_count  <= 16'd0;
    end else begin
      unique case (state)
        BOOT: begin
          state <= RUN;
          if (redirect_valid) pc <= rpc_a;
        end
        RUN: begin
          if (redirect_valid) begin
            pc <= rpc_a;
          end else if (!icache_hit) begin
            state       <= MISS;
            refill_req  <= 1'b1;
            refill_addr <= line_addr;
            if (miss_count != 16'hFFFF)
              miss_count <= miss_count + 16'd1;
          end else if (dq_ready) begin
            pc <= pc_check_enable ? pcn_a : seq_pc;
          end
        end
        MISS: begin
          if (refill_ack) begin
            state      <= RUN;
            refill_req <= 1'b0;
            if (redirect_valid) pc <= rpc_a;
          end else if (redirect_valid) begin
            pending_pc <= rpc_a;
            state      <= MISS_FLUSH;
          end
        end
        MISS_FLUSH: begin
          // refill always completes; youngest redirect wins
          if (refill_ack) begin
            state      <= RUN;
            refill_req <= 1'b0;
            pc <= redirect_valid ? rpc_a : pending_pc;
          end else if (redirect_valid) begin
            pending_pc <= rpc_a;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl.
// Vectors run back to back from a fresh reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_check_enable;
  logic [31:0] pc_check_new;
  logic [2:0]  valid_number;
  logic        icache_hit;
  logic        dq_ready;
  logic        bundle_valid;
  logic [2:0]  bundle_count;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        refill_req;
  logic [31:0] refill_addr;
  logic        refill_ack;
  logic [15:0] miss_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc(pc),
    .pc_check_enable(pc_check_enable),
    .pc_check_new(pc_check_new),
    .valid_number(valid_number),
    .icache_hit(icache_hit),
    .dq_ready(dq_ready),
    .bundle_valid(bundle_valid),
    .bundle_count(bundle_count),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .refill_req(refill_req),
    .refill_addr(refill_addr),
    .refill_ack(refill_ack),
    .miss_count(miss_count)
  );

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        hit;
    logic        rdy;
    logic        pce;
    logic [31:0] pcn;
    logic [2:0]  vn;
    logic        ack;
    logic        bv;
    logic [2:0]  bc;
    logic [31:0] epc;
    logic        req;
    logic [31:0] ra;
    logic [15:0] mc;
  } vec_t;

  vec_t v[27];

  function automatic vec_t mk(
    logic rv, logic [31:0] rpc, logic hit,
    logic rdy, logic pce, logic [31:0] pcn,
    logic [2:0] vn, logic ack, logic bv,
    logic [2:0] bc, logic [31:0] epc,
    logic req, logic [31:0] ra,
    logic [15:0] mc);
    vec_t r;
    r.rv = rv; r.rpc = rpc; r.hit = hit;
    r.rdy = rdy; r.pce = pce; r.pcn = pcn;
    r.vn = vn; r.ack = ack; r.bv = bv;
    r.bc = bc; r.epc = epc; r.req = req;
    r.ra = ra; r.mc = mc;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    redirect_valid  = x.rv;
    redirect_pc     = x.rpc;
    icache_hit      = x.hit;
    dq_ready        = x.rdy;
    pc_check_enable = x.pce;
    pc_check_new    = x.pcn;
    valid_number    = x.vn;
    refill_ack      = x.ack;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_pc", pc, 32'hBFC0_0000);
    chk("rst_req", {31'd0, refill_req}, 32'd0);
    chk("rst_ra", refill_addr, 32'd0);
    chk("rst_mc", {16'd0, miss_count}, 32'd0);
  endtask

  initial begin
    // rv rpc hit rdy pce pcn vn ack | bv bc pc req ra mc
    v[0]  = mk(0, 0, 1, 1, 1, 32'hBFC0_0010, 4, 0,
               0, 0, 32'hBFC0_0000, 0, 0, 0);
    v[1]  = mk(0, 0, 1, 1, 1, 32'hBFC0_0010, 4, 0,
               1, 4, 32'hBFC0_0010, 0, 0, 0);
    v[2]  = mk(0, 0, 1, 1, 1, 32'hBFC0_0020, 4, 0,
               1, 4, 32'hBFC0_0020, 0, 0, 0);
    v[3]  = mk(0, 0, 1, 0, 1, 32'hBFC0_0030, 4, 0,
               1, 4, 32'hBFC0_0020, 0, 0, 0);
    v[4]  = mk(0, 0, 1, 0, 1, 32'hBFC0_0030, 4, 0,
               1, 4, 32'hBFC0_0020, 0, 0, 0);
    v[5]  = mk(0, 0, 1, 0, 1, 32'hBFC0_0030, 4, 0,
               1, 4, 32'hBFC0_0020, 0, 0, 0);
    v[6]  = mk(0, 0, 1, 1, 0, 32'hBFC0_0030, 3, 0,
               1, 3, 32'hBFC0_002C, 0, 0, 0);
    v[7]  = mk(1, 32'h1234_5679, 0, 1, 0, 0, 4, 0,
               0, 0, 32'h1234_5678, 0, 0, 0);
    v[8]  = mk(0, 0, 0, 1, 0, 0, 4, 0,
               0, 0, 32'h1234_5678, 1, 32'h1234_5670, 1);
    v[9]  = mk(0, 0, 0, 1, 0, 0, 4, 0,
               0, 0, 32'h1234_5678, 1, 32'h1234_5670, 1);
    v[10] = mk(0, 0, 1, 1, 0, 0, 4, 0,
               0, 0, 32'h1234_5678, 1, 32'h1234_5670, 1);
    v[11] = mk(0, 0, 1, 1, 0, 0, 4, 0,
               0, 0, 32'h1234_5678, 1, 32'h1234_5670, 1);
    v[12] = mk(0, 0, 0, 1, 0, 0, 4, 0,
               0, 0, 32'h1234_5678, 1, 32'h1234_5670, 1);
    v[13] = mk(0, 0, 0, 1, 0, 0, 4, 1,
               0, 0, 32'h1234_5678, 0, 32'h1234_5670, 1);
    v[14] = mk(0, 0, 1, 1, 1, 32'h1234_5688, 4, 0,
               1, 4, 32'h1234_5688, 0, 32'h1234_5670, 1);
    v[15] = mk(0, 0, 0, 1, 1, 0, 4, 0,
               0, 0, 32'h1234_5688, 1, 32'h1234_5680, 2);
    v[16] = mk(1, 32'h8000_0100, 1, 1, 0, 0, 4, 0,
               0, 0, 32'h1234_5688, 1, 32'h1234_5680, 2);
    v[17] = mk(1, 32'h8000_0200, 1, 1, 0, 0, 4, 0,
               0, 0, 32'h1234_5688, 1, 32'h1234_5680, 2);
    v[18] = mk(0, 0, 1, 1, 0, 0, 4, 1,
               0, 0, 32'h8000_0200, 0, 32'h1234_5680, 2);
    v[19] = mk(0, 0, 0, 1, 0, 0, 4, 0,
               0, 0, 32'h8000_0200, 1, 32'h8000_0200, 3);
    v[20] = mk(1, 32'h9000_0000, 0, 1, 0, 0, 4, 1,
               0, 0, 32'h9000_0000, 0, 32'h8000_0200, 3);
    v[21] = mk(0, 0, 1, 1, 1, 32'hFFFF_FFFC, 4, 0,
               1, 4, 32'hFFFF_FFFC, 0, 32'h8000_0200, 3);
    v[22] = mk(0, 0, 1, 1, 0, 0, 2, 0,
               1, 2, 32'h0000_0004, 0, 32'h8000_0200, 3);
    v[23] = mk(0, 0, 0, 1, 0, 0, 2, 0,
               0, 0, 32'h0000_0004, 1, 32'h0000_0000, 4);
    v[24] = mk(1, 32'hA000_0000, 0, 1, 0, 0, 2, 0,
               0, 0, 32'h0000_0004, 1, 32'h0000_0000, 4);
    v[25] = mk(1, 32'hB000_0010, 0, 1, 0, 0, 2, 1,
               0, 0, 32'hB000_0010, 0, 32'h0000_0000, 4);
    v[26] = mk(0, 0, 1, 0, 0, 0, 1, 1,
               1, 1, 32'hB000_0010, 0, 32'h0000_0000, 4);

    drive(v[0]);
    do_reset();

    for (int i = 0; i < 27; i++) begin
      drive(v[i]);
      #1;
      chk($sformatf("v%0d_bv", i),
          {31'd0, bundle_valid}, {31'd0, v[i].bv});
      chk($sformatf("v%0d_bc", i),
          {29'd0, bundle_count}, {29'd0, v[i].bc});
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", i), pc, v[i].epc);
      chk($sformatf("v%0d_req", i),
          {31'd0, refill_req}, {31'd0, v[i].req});
      chk($sformatf("v%0d_ra", i), refill_addr, v[i].ra);
      chk($sformatf("v%0d_mc", i),
          {16'd0, miss_count}, {16'd0, v[i].mc});
    end

    // reset while a refill is outstanding
    drive(mk(0, 0, 0, 1, 0, 0, 4, 0,
             0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("mid_req", {31'd0, refill_req}, 32'd1);
    chk("mid_mc", {16'd0, miss_count}, 32'd5);
    do_reset();
    icache_hit = 1'b1;
    #1;
    chk("boot_bv", {31'd0, bundle_valid}, 32'd0);
    @(posedge clk); #1;
    chk("run_bv", {31'd0, bundle_valid}, 32'd1);
    chk("run_bc", {29'd0, bundle_count}, 32'd4);

    // redirect during BOOT, then push in the next cycle
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    @(posedge clk); #1;
    chk("boot_rd_pc", pc, 32'h0000_0100);
    redirect_valid  = 1'b0;
    pc_check_enable = 1'b0;
    valid_number    = 3'd1;
    #1;
    chk("boot_rd_bv", {31'd0, bundle_valid}, 32'd1);
    @(posedge clk); #1;
    chk("boot_rd_seq", pc, 32'h0000_0104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the fetch stage. It owns the architectural fetch PC register and drives it into the fetch datapath, which is the icache plus four quick-decode slots. Each cycle it decides whether the current fetch bundle is pushed to the decode queue, held, or replaced by a redirect, and it runs the icache miss/refill handshake. The next PC comes from the fetch datapath's branch prediction, a sequential advance, or a backend redirect.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, fetch PC loaded on reset.
- LINE_BYTES, 16, icache line size in bytes (power of two, ≥16); sets refill address alignment.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- pc  out  32  current fetch PC to the fetch datapath; bits [1:0] always 0.
- pc_check_enable  in  1  fetch datapath's next-PC valid.
- pc_check_new  in  32  next PC from the fetch datapath (prediction, or pc+12 / pc+16).
- valid_number  in  3  valid instructions in the bundle (1..4).
- icache_hit  in  1  icache holds the line for `pc` this cycle.
- dq_ready  in  1  decode queue can accept one bundle this cycle.
- bundle_valid  out  1  bundle at `pc` is offered to the decode queue.
- bundle_count  out  3  equals valid_number when bundle_valid=1, else 0.
- redirect_valid  in  1  backend flush (mispredict or exception), one-cycle pulse.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- refill_req  out  1  registered; high while a refill is outstanding.
- refill_addr  out  32  line-aligned miss address: {pc[31:log2(LINE_BYTES)], 0}.
- refill_ack  in  1  one-cycle pulse; the line is written and readable next cycle.
- miss_count  out  16  saturating count of entries into MISS.

## Operation
States: BOOT, RUN, MISS, MISS_FLUSH. A transfer (push) occurs in a cycle when bundle_valid & dq_ready.

- **Reset:**
  - pc=RESET_PC, state=BOOT.
  - refill_req=0, refill_addr=0, miss_count=0, pending_pc=0.
  - bundle_valid=0, bundle_count=0.
- **BOOT:** lasts one cycle, bundle_valid=0, then goes to RUN. If redirect_valid is high, pc←redirect_pc.
- **RUN** (bundle_valid = icache_hit & ~redirect_valid), first match wins:
  1. redirect_valid: pc←redirect_pc, no push, stay in RUN.
  2. ~icache_hit: go to MISS, latch refill_addr from pc, miss_count+1 (saturates at 16'hFFFF), pc held.
  3. Push: pc←pc_check_new if pc_check_enable, else pc+4·valid_number (mod 2^32).
  4. Otherwise (hit & ~dq_ready): hold pc, no change.
- **MISS** (bundle_valid=0, refill_req=1):
  - redirect_valid & refill_ack: go to RUN, pc←redirect_pc.
  - redirect_valid alone: pending_pc←redirect_pc, go to MISS_FLUSH.
  - refill_ack alone: go to RUN, pc unchanged (refetch).
- **MISS_FLUSH** (bundle_valid=0, refill_req=1):
  - The refill is never aborted; the controller waits for refill_ack.
  - A further redirect overwrites pending_pc (youngest redirect wins).
  - On refill_ack: go to RUN, pc←pending_pc, or redirect_pc if a redirect arrives in the same cycle.
- **Boundaries:**
  - pc wraps past 32'hFFFF_FFFC.
  - refill_ack in RUN or BOOT is ignored.
  - rst mid-miss drops refill_req the next cycle; no ack is awaited.

## Timing
- bundle_valid and bundle_count are combinational from state, icache_hit, redirect_valid and valid_number.
- pc, refill_req, refill_addr and miss_count are registered.
- Sequential bundle throughput is 1 per cycle while dq_ready=1 and hits continue.
- Miss detected at cycle N: refill_req=1 at N+1.
- refill_ack at cycle M: refill_req=0 at M+1, state is RUN at M+1, and the earliest push is at M+1.
- Redirect at cycle N: pc=redirect_pc at N+1, earliest push at N+1.
- dq_ready is sampled only in RUN; its value in other states is don't-care.

## Test plan
- **Reset then sequential hits:** rst pulse, icache_hit=1, dq_ready=1, valid_number=4, pc_check_new=pc+16 → pc sequence BFC00000, BFC00010, BFC00020; bundle_valid=1 from cycle 2 after rst.
- **Backpressure:** hit, dq_ready=0 for 3 cycles → pc constant, bundle_valid=1, no pc advance. dq_ready→1 → pc←pc_check_new next cycle.
- **Miss/refill:** pc=0x1234_5678, icache_hit=0 → refill_req=1 next cycle, refill_addr=0x1234_5670, miss_count=1. refill_ack after 5 cycles → pc=0x1234_5678 in RUN, refill_req=0.
- **Redirect during miss:** in MISS, redirect to 0x8000_0100, then to 0x8000_0200, then refill_ack → pc=0x8000_0200. No push before ack.
- **Simultaneous redirect and miss:** redirect_valid=1 with icache_hit=0 in RUN → pc=redirect_pc, no MISS entry, miss_count unchanged. Simultaneous redirect and ack in MISS → RUN at redirect_pc.
- **Reset mid-miss:** rst while refill_req=1 → next cycle refill_req=0, pc=RESET_PC, state BOOT, miss_count=0.
